// File: rtl/adder_6bit_pkg.sv
// rtl/adder_6bit_pkg.sv - shared widths and types for the 6-bit adder
package adder_6bit_pkg;

  localparam int OPERAND_W = 6;
  localparam int SUM_W     = OPERAND_W + 1;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [SUM_W-1:0]     sum_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell used by the ripple-carry core
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_6bit.sv
// rtl/adder_6bit.sv - unsigned 6-bit adder, 7-bit combinational and registered sum; ADDER_6BIT_CLA_EN selects carry-lookahead
module adder_6bit
  import adder_6bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] x,
  input  logic [OPERAND_W-1:0] y,
  output logic [SUM_W-1:0]     s,
  output logic [SUM_W-1:0]     s_q
);

  logic [OPERAND_W:0] c;

`ifdef ADDER_6BIT_CLA_EN
  logic [OPERAND_W-1:0] g;
  logic [OPERAND_W-1:0] p;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is a flat OR of generate terms propagated through the bits above them.
  always_comb begin : cla_carry
    logic term;
    term = 1'b0;
    c    = '0;
    for (int i = 0; i < OPERAND_W; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
  end

  for (genvar i = 0; i < OPERAND_W; i++) begin : g_cla_sum
    assign s[i] = p[i] ^ c[i];
  end
`else
  assign c[0] = 1'b0;

  for (genvar i = 0; i < OPERAND_W; i++) begin : g_ripple
    full_adder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end
`endif

  assign s[SUM_W-1] = c[OPERAND_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s;
    end
  end

endmodule

// File: tb/tb_adder_6bit.sv
// tb/tb_adder_6bit.sv - scoreboard bench for adder_6bit: sweep, boundaries, registered path and async reset
module tb_adder_6bit;
  import adder_6bit_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] x;
  logic [5:0] y;
  logic [6:0] s;
  logic [6:0] s_q;

  int total = 0;
  int bad   = 0;
  logic [6:0] sb_q[$];

  adder_6bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .s     (s),
    .s_q   (s_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [5:0] b);
    sb_q.push_back(7'(a) + 7'(b));
  endtask

  task automatic pop_check(input string tag, input logic [6:0] obs);
    logic [6:0] exp;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      check(tag, obs, exp);
    end
  endtask

  task automatic comb_step(input string tag, input logic [5:0] a, input logic [5:0] b);
    x = a;
    y = b;
    push(a, b);
    #1;
    pop_check(tag, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ra;
    logic [5:0] rb;
    rst_n = 1'b0;
    x = '0;
    y = '0;
    #1;
    check("powerup_s_q", s_q, 7'd0);

    comb_step("bnd_0_0",   6'd0,  6'd0);
    comb_step("bnd_63_63", 6'd63, 6'd63);
    comb_step("bnd_1_63",  6'd1,  6'd63);
    comb_step("bnd_32_32", 6'd32, 6'd32);

    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        comb_step("sweep", 6'(i), 6'(j));
      end
    end
    check("reset_hold_s_q", s_q, 7'd0);

    @(negedge clk);
    rst_n = 1'b1;
    x = 6'd10; y = 6'd5; push(x, y);
    @(posedge clk); #1;
    pop_check("reg_10_5", s_q);
    @(negedge clk);
    x = 6'd40; y = 6'd30; push(x, y);
    @(posedge clk); #1;
    pop_check("reg_40_30", s_q);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_s_q", s_q, 7'd0);
    check("async_rst_s", s, 7'd70);
    @(negedge clk);
    rst_n = 1'b1;
    push(x, y);
    @(posedge clk); #1;
    pop_check("rst_release_s_q", s_q);

    @(negedge clk);
    x = 6'd1; y = 6'd2;
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_discard", s_q, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(x, y);
    @(posedge clk); #1;
    pop_check("mid_rst_release", s_q);

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      x = ra;
      y = rb;
      push(ra, rb);
      @(posedge clk); #1;
      pop_check("b2b_s_q", s_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
